stg_game_ctrl: RTL

//  Parametrised top-level game-flow controller for the STG core: intro, start, play, pause, hit-invulnerability,

---
 rtl/stg_game_pkg.sv | 30 +++
 rtl/stg_phase_timer.sv | 28 ++
 rtl/stg_game_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/stg_game_pkg.sv
// Shared state encoding and default constants for the STG game-flow controller.
package stg_game_pkg;

  localparam int unsigned CNT_W_DEF     = 4;
  localparam int unsigned TMR_W_DEF     = 32;
  localparam int unsigned INTRO_CYC_DEF = 20_000_000;
  localparam int unsigned HIT_CYC_DEF   = 200_000_000;
  localparam int unsigned BOMB_CYC_DEF  = 400_000_000;

  typedef enum logic [4:0] {
    ST_INIT  = 5'b00000,
    ST_START = 5'b00001,
    ST_PLAY  = 5'b00010,
    ST_PAUSE = 5'b00100,
    ST_HIT   = 5'b01010,
    ST_BOMB  = 5'b00110,
    ST_OVER  = 5'b01001
  } state_t;

  // Playfield advances in these states.
  function automatic logic is_live(input state_t s);
    return (s == ST_PLAY) || (s == ST_HIT) || (s == ST_BOMB);
  endfunction

  // Life/bomb awards are accepted in these states.
  function automatic logic is_award(input state_t s);
    return is_live(s) || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/stg_phase_timer.sv
// Down-counting phase timer: load overrides decrement, holds at zero.
module stg_phase_timer #(
  parameter int unsigned     TMR_W   = 32,
  parameter logic [TMR_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [TMR_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= RST_VAL;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - TMR_W'(1);
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/stg_game_ctrl.sv
// Top-level STG game-flow controller: phase FSM, life/bomb counters, playfield control.
// Optional PAUSE phase enabled by defining STG_GAME_PAUSE_EN.
module stg_game_ctrl
  import stg_game_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned INIT_LIVES = 3,
  parameter int unsigned INIT_BOMBS = 3,
  parameter int unsigned MAX_LIVES  = 9,
  parameter int unsigned MAX_BOMBS  = 9,
  parameter int unsigned TMR_W      = TMR_W_DEF,
  parameter int unsigned INTRO_CYC  = INTRO_CYC_DEF,
  parameter int unsigned HIT_CYC    = HIT_CYC_DEF,
  parameter int unsigned BOMB_CYC   = BOMB_CYC_DEF
) (
  input  logic             clk,
  input  logic             hard_reset_n,
  input  logic             enter,
  input  logic             bomb,
  input  logic             collision,
  input  logic             life_up,
  input  logic             bomb_up,
  output logic [CNT_W-1:0] num_life,
  output logic [CNT_W-1:0] num_bomb,
  output logic [4:0]       game_state,
  output logic             game_en,
  output logic             game_reset,
  output logic             invuln
);

  localparam logic [TMR_W-1:0] INTRO_LOAD = TMR_W'(INTRO_CYC - 1);
  localparam logic [TMR_W-1:0] HIT_LOAD   = TMR_W'(HIT_CYC - 1);
  localparam logic [TMR_W-1:0] BOMB_LOAD  = TMR_W'(BOMB_CYC - 1);
  localparam logic [CNT_W-1:0] LIFE_INIT  = CNT_W'(INIT_LIVES);
  localparam logic [CNT_W-1:0] BOMB_INIT  = CNT_W'(INIT_BOMBS);
  localparam logic [CNT_W-1:0] LIFE_MAX   = CNT_W'(MAX_LIVES);
  localparam logic [CNT_W-1:0] BOMB_MAX   = CNT_W'(MAX_BOMBS);

  state_t           state_q, state_d;
  logic             enter_q, bomb_q;
  logic             enter_rise, bomb_rise;
  logic [CNT_W-1:0] life_q, life_d;
  logic [CNT_W-1:0] bombs_q, bombs_d;
  logic             game_en_q, game_reset_q, invuln_q;

  logic             tmr_load, tmr_dec, tmr_zero_c;
  logic [TMR_W-1:0] tmr_val;
  logic             life_dec, bomb_dec, reload, clr_pulse;
  logic             life_inc, bomb_inc, award_ok;

  assign enter_rise = enter & ~enter_q;
  assign bomb_rise  = bomb & ~bomb_q;
  assign tmr_dec    = (state_q == ST_INIT) || (state_q == ST_HIT) || (state_q == ST_BOMB);

  stg_phase_timer #(
    .TMR_W   (TMR_W),
    .RST_VAL (INTRO_LOAD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (hard_reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero_c   (tmr_zero_c)
  );

  // State register, edge detectors, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!hard_reset_n) begin
      state_q      <= ST_INIT;
      enter_q      <= 1'b0;
      bomb_q       <= 1'b0;
      life_q       <= LIFE_INIT;
      bombs_q      <= BOMB_INIT;
      game_en_q    <= 1'b0;
      game_reset_q <= 1'b0;
      invuln_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      enter_q      <= enter;
      bomb_q       <= bomb;
      life_q       <= life_d;
      bombs_q      <= bombs_d;
      game_en_q    <= is_live(state_d);
      game_reset_q <= clr_pulse;
      invuln_q     <= (state_d == ST_HIT) || (state_d == ST_BOMB);
    end
  end

  // Next-state and phase-transition side effects.
  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    life_dec  = 1'b0;
    bomb_dec  = 1'b0;
    reload    = 1'b0;
    clr_pulse = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (tmr_zero_c) state_d = ST_START;
      end
      ST_START: begin
        if (enter_rise) begin
          state_d   = ST_PLAY;
          clr_pulse = 1'b1;
        end
      end
      ST_PLAY: begin
        if (collision) begin
          if (life_q == '0) begin
            state_d = ST_OVER;
          end else begin
            state_d  = ST_HIT;
            life_dec = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = HIT_LOAD;
          end
        end else if (bomb_rise) begin
          if (bombs_q != '0) begin
            state_d  = ST_BOMB;
            bomb_dec = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = BOMB_LOAD;
          end
        end
`ifdef STG_GAME_PAUSE_EN
        else if (enter_rise) begin
          state_d = ST_PAUSE;
        end
`endif
      end
      ST_HIT: begin
        if (bomb_rise && (bombs_q != '0)) begin
          state_d  = ST_BOMB;
          bomb_dec = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = BOMB_LOAD;
        end else if (tmr_zero_c) begin
          state_d = ST_PLAY;
        end
      end
      ST_BOMB: begin
        if (tmr_zero_c) state_d = ST_PLAY;
      end
`ifdef STG_GAME_PAUSE_EN
      ST_PAUSE: begin
        if (enter_rise) state_d = ST_PLAY;
      end
`endif
      ST_OVER: begin
        if (enter_rise) begin
          state_d   = ST_INIT;
          reload    = 1'b1;
          clr_pulse = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = INTRO_LOAD;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Counter update: award and consume in the same cycle cancel out.
  always_comb begin
    award_ok = is_award(state_q) && (state_d != ST_OVER);
    life_inc = life_up && award_ok;
    bomb_inc = bomb_up && award_ok;
    life_d   = life_q;
    bombs_d  = bombs_q;
    if (reload) begin
      life_d = LIFE_INIT;
    end else if (life_inc && !life_dec) begin
      if (life_q < LIFE_MAX) life_d = life_q + CNT_W'(1);
    end else if (life_dec && !life_inc) begin
      life_d = life_q - CNT_W'(1);
    end
    if (reload) begin
      bombs_d = BOMB_INIT;
    end else if (bomb_inc && !bomb_dec) begin
      if (bombs_q < BOMB_MAX) bombs_d = bombs_q + CNT_W'(1);
    end else if (bomb_dec && !bomb_inc) begin
      bombs_d = bombs_q - CNT_W'(1);
    end
  end

  assign num_life   = life_q;
  assign num_bomb   = bombs_q;
  assign game_state = state_q;
  assign game_en    = game_en_q;
  assign game_reset = game_reset_q;
  assign invuln     = invuln_q;

endmodule
